// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multi-cycle datapath blocks.
//   WORD_W       : datapath word width
//   mult_state_t : booth_mult_unit sequencer state encoding
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_RUN  = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/booth_mult_unit_if.sv
// Handshake/operand/result bundle between the control unit and booth_mult_unit.
//   start          : request, sampled by the unit only in IDLE and DONE
//   a_in, b_in     : signed multiplicand / multiplier
//   busy, done     : iterating / one-cycle completion pulse
//   hi_out, lo_out : registered upper / lower product halves
// master = requester (control unit / bench), slave = multiplier.
interface booth_mult_unit_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   i_acc/i_q/i_q1 : current {ACC, Q, q_1}; ACC carries one guard bit
//   i_m            : multiplicand
//   o_acc/o_q/o_q1 : {ACC, Q, q_1} after add/subtract and arithmetic shift right
module booth_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;

  // Guard bit keeps ACC +/- M exact when M is the most-negative value.
  assign w_m_ext = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_acc + w_m_ext;
      2'b10:   w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
  end

  assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q1  = i_q[0];

endmodule

// File: rtl/booth_mult_unit.sv
// Multi-cycle signed WIDTH x WIDTH radix-2 Booth multiplier (MULT).
//   clk    : system clock
//   reset  : synchronous active-low reset
//   mif    : slave side of booth_mult_unit_if (start/a_in/b_in in,
//            busy/done/hi_out/lo_out out)
// One Booth step per clock in RUN; WIDTH steps, then a one-cycle DONE.
// CNT_W must satisfy 2**CNT_W > WIDTH.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// MULT_IDLE | waiting for start; results held
// MULT_RUN  | iterating, one Booth step per edge, busy=1
// MULT_DONE | one-cycle done pulse; start here reloads straight into RUN
module booth_mult_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input logic              clk,
  input logic              reset,
  booth_mult_unit_if.slave mif
);

  mult_state_t      r_state;
  mult_state_t      w_state_nxt;
  logic             w_load;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_q1  (w_q1_nxt)
  );

  // Counter holds the number of steps already done; the step taken while it
  // reads WIDTH-1 is the final one.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= MULT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      MULT_IDLE: begin
        if (mif.start) begin
          w_load      = 1'b1;
          w_state_nxt = MULT_RUN;
        end
      end
      MULT_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = MULT_DONE;
        end
      end
      MULT_DONE: begin
        w_done = 1'b1;
        if (mif.start) begin
          w_load      = 1'b1;
          w_state_nxt = MULT_RUN;
        end else begin
          w_state_nxt = MULT_IDLE;
        end
      end
      default: begin
        w_state_nxt = MULT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_m   <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_load) begin
      r_m   <= mif.a_in;
      r_acc <= '0;
      r_q   <= mif.b_in;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == MULT_RUN) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= w_q1_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // Product sits in {ACC[WIDTH-1:0], Q}; the guard bit is just sign.
        r_hi <= w_acc_nxt[WIDTH-1:0];
        r_lo <= w_q_nxt;
      end
    end
  end

  assign mif.busy   = w_busy;
  assign mif.done   = w_done;
  assign mif.hi_out = r_hi;
  assign mif.lo_out = r_lo;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Self-checking bench for booth_mult_unit: scoreboard of reference products,
// one task per scenario, inputs driven and outputs sampled on negedge.
module tb_booth_mult_unit;
  import cpu_pkg::*;

  localparam int W = WORD_W;

  logic clk = 1'b0;
  logic reset;

  booth_mult_unit_if #(.WIDTH(W)) mif ();

  booth_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Caller is at a negedge; start is sampled on the following posedge (E0).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    mif.start = 1'b1;
    mif.a_in  = a;
    mif.b_in  = b;
    sb.push_back(ref_prod(a, b));
  endtask

  // Negedge k after issue sits between E0+k-1 and E0+k, so done shows at k=33
  // and busy is seen for k=1..32. Operands are scrambled after E0.
  task automatic wait_done(input int poke_k, output int done_k, output int busy_cnt,
                           output bit held, output bit first_busy);
    done_k     = -1;
    busy_cnt   = 0;
    held       = 1'b1;
    first_busy = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.start  = 1'b0;
        mif.a_in   = $urandom;
        mif.b_in   = $urandom;
        first_busy = mif.busy;
      end
      if (k == poke_k) begin
        mif.start = 1'b1;
        mif.a_in  = 32'd100;
        mif.b_in  = 32'd100;
      end
      if (k == poke_k + 1) mif.start = 1'b0;
      if (mif.busy) busy_cnt++;
      if (mif.done) begin
        done_k = k;
        break;
      end
      if (mif.hi_out !== prev_hi || mif.lo_out !== prev_lo) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mif.start = 1'b1;
    mif.a_in  = 32'd3;
    mif.b_in  = 32'd4;
    repeat (3) @(negedge clk);
    n_vec++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    n_vec++; if (mif.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", mif.done); end
    n_vec++; if (mif.hi_out !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", mif.hi_out); end
    n_vec++; if (mif.lo_out !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", mif.lo_out); end
    mif.start = 1'b0;
    reset     = 1'b1;
    prev_hi   = '0;
    prev_lo   = '0;
    @(negedge clk);
    n_vec++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", mif.busy); end
  endtask

  task automatic test_signed_small();
    int dk, bc;
    bit hd, fb;
    logic [2*W-1:0] exp;
    issue(32'd7, 32'hFFFF_FFFD);
    wait_done(0, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if (dk !== 33) begin n_err++; $display("FAIL small_latency: got %0d want 33", dk); end
    n_vec++; if (bc !== 32) begin n_err++; $display("FAIL small_busy_cycles: got %0d want 32", bc); end
    n_vec++; if (hd !== 1'b1) begin n_err++; $display("FAIL small_hold: got %b want 1", hd); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL small_result: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    n_vec++; if (mif.lo_out !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL small_lo_const: got %h want ffffffeb", mif.lo_out); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    @(negedge clk);
    n_vec++; if (mif.done !== 1'b0) begin n_err++; $display("FAIL small_done_pulse: got %b want 0", mif.done); end
    n_vec++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL small_idle: got %b want 0", mif.busy); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL small_hold_idle: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
  endtask

  task automatic test_most_negative();
    int dk, bc;
    bit hd, fb;
    logic [2*W-1:0] exp;
    issue(32'h8000_0000, 32'h8000_0000);
    wait_done(0, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if (dk !== 33) begin n_err++; $display("FAIL mneg_latency: got %0d want 33", dk); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL mneg_result: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    n_vec++; if (mif.hi_out !== 32'h4000_0000) begin n_err++; $display("FAIL mneg_hi_const: got %h want 40000000", mif.hi_out); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dk, bc;
    bit hd, fb;
    logic [2*W-1:0] exp;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL b2b_first: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    // Still in DONE: start here must reload without an IDLE cycle.
    issue(32'h0001_2345, 32'h0001_0000);
    wait_done(0, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if (fb !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble: busy got %b want 1", fb); end
    n_vec++; if (dk !== 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33", dk); end
    n_vec++; if (hd !== 1'b1) begin n_err++; $display("FAIL b2b_hold: got %b want 1", hd); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL b2b_second: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int dk, bc, extra;
    bit hd, fb;
    logic [2*W-1:0] exp;
    issue(32'd5, 32'd6);
    wait_done(10, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if (dk !== 33) begin n_err++; $display("FAIL ign_latency: got %0d want 33", dk); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL ign_result: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mif.done || mif.busy) extra++;
    end
    n_vec++; if (extra !== 0) begin n_err++; $display("FAIL ign_extra_activity: got %0d want 0", extra); end
  endtask

  task automatic test_reset_midrun();
    int dk, bc, dones;
    bit hd, fb;
    logic [2*W-1:0] exp;
    issue(32'd5, 32'd6);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) mif.start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", mif.busy); end
    n_vec++; if (mif.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", mif.done); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== 64'd0) begin n_err++; $display("FAIL midrst_result: got %h%h want 0", mif.hi_out, mif.lo_out); end
    sb.delete();
    prev_hi = '0;
    prev_lo = '0;
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mif.done) dones++;
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
    issue(32'd5, 32'd6);
    wait_done(0, dk, bc, hd, fb);
    exp = sb.pop_front();
    n_vec++; if (dk !== 33) begin n_err++; $display("FAIL midrst_restart_latency: got %0d want 33", dk); end
    n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL midrst_restart_result: got %h%h want %h", mif.hi_out, mif.lo_out, exp); end
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
    @(negedge clk);
  endtask

  task automatic test_random();
    int dk, bc;
    bit hd, fb;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 1000; i++) begin
      issue(pick_operand(), pick_operand());
      wait_done(0, dk, bc, hd, fb);
      exp = sb.pop_front();
      n_vec++; if (dk !== 33) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want 33", i, dk); end
      n_vec++; if (hd !== 1'b1) begin n_err++; $display("FAIL rnd_hold[%0d]: got %b want 1", i, hd); end
      n_vec++; if ({mif.hi_out, mif.lo_out} !== exp) begin n_err++; $display("FAIL rnd_result[%0d]: got %h%h want %h", i, mif.hi_out, mif.lo_out, exp); end
      prev_hi = exp[2*W-1:W];
      prev_lo = exp[W-1:0];
      if (i % 3 == 0) @(negedge clk);
    end
  endtask

  initial begin
    mif.start = 1'b0;
    mif.a_in  = '0;
    mif.b_in  = '0;
    reset     = 1'b0;
    prev_hi   = '0;
    prev_lo   = '0;
    @(negedge clk);
    test_reset();
    test_signed_small();
    test_most_negative();
    test_back_to_back();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
